// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the WIDTH sanity check macro.
`ifndef SERIAL_PKG_SV
`define SERIAL_PKG_SV

// Elaboration-time guard: a serial unit needs at least two bit steps
// so that the carry into the MSB is a distinct, registered value.
`define SERIAL_WIDTH_CHECK(W) \
   if ((W) < 2) begin : g_width_chk \
      $error("serial_addsub: WIDTH must be >= 2"); \
   end

package serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

`endif

// File: rtl/serial_fa.sv
// serial_fa: combinational 1-bit full adder cell.
// Ports: x, y, z operand/carry in; s sum out; c carry out.
module serial_fa (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: WIDTH-generic bit-serial add/sub, LSB first.
// Ports: clk, rst_n, start/sub/a/b in; sum/cout/ovf/busy/done out.
module serial_addsub
   import serial_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   `SERIAL_WIDTH_CHECK(WIDTH)

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             fa_s;
   logic             fa_c;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] res_nxt;

   serial_fa u_fa (
      .x (a_q[0]),
      .y (b_q[0]),
      .z (c_q),
      .s (fa_s),
      .c (fa_c)
   );

   assign accept  = start && (state_q != RUN);
   assign last    = (cnt_q == CNT_W'(WIDTH - 1));
   assign res_nxt = {fa_s, res_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            res_d = res_nxt;
            c_d   = fa_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
               // c_q is the carry into the MSB on this step
               sum_d   = res_nxt;
               cout_d  = fa_c;
               ovf_d   = c_q ^ fa_c;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = start ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         // subtract as a + ~b + 1: invert b, seed carry with 1
         a_d   = a;
         b_d   = sub ? ~b : b;
         c_d   = sub;
         cnt_d = '0;
         res_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule
